// File: rtl/forward_scoreboard.sv
// Operand forwarding with a pending scoreboard for multi-cycle writes. Operands and stall are combinational; scoreboard state updates in 1 cycle.
// No buffering: any operand, structural or WAW hazard raises stall, which holds the decode instruction.
module forward_scoreboard #(
    parameter int XLEN     = 64,
    parameter int AW       = 5,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NSRC     = 3,
    parameter int MC_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    ra,
    input  logic [NRD*XLEN-1:0]  rd,
    input  logic [NSRC-1:0]      src_valid,
    input  logic [NSRC*AW-1:0]   src_wa,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [NSRC-1:0]      src_ready,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_wa,
    input  logic                 issue_multi,
    input  logic                 mc_done,
    input  logic [AW-1:0]        mc_wa,
    input  logic [XLEN-1:0]      mc_data,
    input  logic                 flush,
    output logic [NRD*XLEN-1:0]  rs,
    output logic                 stall,
    output logic [NREG-1:0]      pending,
    output logic [2:0]           mc_count,
    output logic [31:0]          stall_cycles
);

    localparam logic [2:0] MC_MAX = 3'(MC_DEPTH);

    logic [NRD-1:0]  port_stall;
    logic [AW-1:0]   port_addr;
    logic [XLEN-1:0] port_data;
    logic            port_hold;
    logic            issue_gate;
    logic            mc_full;
    logic            waw_hazard;
    logic            accept;
    logic            pend_set;
    logic            pend_clr;
    logic            cnt_inc;
    logic            cnt_dec;
    logic [NREG-1:0] pending_nxt;

    // Per-port resolution. The source loop runs oldest to youngest so the
    // youngest matching in-flight writer overrides older ones.
    always_comb begin
        rs         = '0;
        port_stall = '0;
        port_addr  = '0;
        port_data  = '0;
        port_hold  = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            port_addr = ra[p*AW +: AW];
            port_data = rd[p*XLEN +: XLEN];
            port_hold = 1'b0;
            if (port_addr == '0) begin
                port_data = '0;
            end else if (mc_done && mc_wa == port_addr) begin
                port_data = mc_data;
            end else if (pending[port_addr]) begin
                port_hold = 1'b1;
            end else begin
                for (int i = NSRC - 1; i >= 0; i--) begin
                    if (src_valid[i] && src_wa[i*AW +: AW] == port_addr) begin
                        port_data = src_data[i*XLEN +: XLEN];
                        port_hold = !src_ready[i];
                    end
                end
            end
            port_stall[p]          = port_hold;
            rs[p*XLEN +: XLEN]     = reset ? port_data : '0;
        end
    end

    // A writeback landing this cycle frees its slot / register in time for the issue.
    assign mc_full    = (mc_count == MC_MAX) && !mc_done;
    assign waw_hazard = (issue_wa != '0) && pending[issue_wa] &&
                        !(mc_done && mc_wa == issue_wa);
    assign issue_gate = reset && issue_valid && !flush;
    assign stall      = issue_gate &&
                        ((|port_stall) || (issue_multi && mc_full) || waw_hazard);
    assign accept     = issue_gate && !stall;

    assign pend_set = accept && issue_multi && (issue_wa != '0);
    assign pend_clr = mc_done && (mc_wa != '0);
    assign cnt_inc  = accept && issue_multi;
    assign cnt_dec  = mc_done && (mc_count != 3'd0);

    // Set takes priority over clear when both hit the same register.
    always_comb begin
        pending_nxt = '0;
        for (int r = 1; r < NREG; r++) begin
            pending_nxt[r] = (pend_set && issue_wa == AW'(r)) ||
                             (pending[r] && !(pend_clr && mc_wa == AW'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending      <= '0;
            mc_count     <= 3'd0;
            stall_cycles <= 32'd0;
        end else begin
            pending <= pending_nxt;
            case ({cnt_inc, cnt_dec})
                2'b10:   mc_count <= mc_count + 3'd1;
                2'b01:   mc_count <= mc_count - 3'd1;
                default: mc_count <= mc_count;
            endcase
            if (stall && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised successor to the single-cycle operand forwarder.
- Resolves operands for NRD read ports from NSRC in-flight pipeline sources plus one multi-cycle (mul/div) writeback port.
- Holds a per-register pending scoreboard for outstanding multi-cycle writes and generates a unified decode-stage stall.
- Sits between the regfile read in decode and the decode/execute pipeline register; also keeps a saturating stall-cycle performance counter.

Parameters:
XLEN, 64, data width
AW, 5, register address width
NREG, 32, architectural registers (2**AW)
NRD, 2, operand read ports
NSRC, 3, forwarding sources, index 0 youngest (EX), NSRC-1 oldest (WB)
MC_DEPTH, 2, max outstanding multi-cycle ops (1..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
ra  in  NRD*AW  per-port source register address
rd  in  NRD*XLEN  per-port regfile read data
src_valid  in  NSRC  source holds a register-writing instruction
src_wa  in  NSRC*AW  source destination address
src_data  in  NSRC*XLEN  source result
src_ready  in  NSRC  result available this cycle (0 e.g. load in EX)
issue_valid  in  1  decode instruction attempts to advance this cycle
issue_wa  in  AW  its destination (0 = none)
issue_multi  in  1  it is a multi-cycle op
mc_done  in  1  multi-cycle unit writes back this cycle
mc_wa  in  AW  multi-cycle destination
mc_data  in  XLEN  multi-cycle result
flush  in  1  kill decode instruction this cycle
rs  out  NRD*XLEN  resolved operands
stall  out  1  hold decode/fetch
pending  out  NREG  scoreboard bits
mc_count  out  3  outstanding multi-cycle ops
stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Combinational per port p, first match wins:
  - ra==0: rs=0, no stall.
  - mc_done & mc_wa==ra: rs=mc_data.
  - pending[ra]: stall.
  - Lowest-index i with src_valid[i] & src_wa[i]==ra: rs=src_data[i] if src_ready[i], else stall.
  - Otherwise rs=rd.
- Structural/WAW stall when issue_valid & !flush and either:
  - issue_multi & mc_count==MC_DEPTH & !mc_done, or
  - issue_wa!=0 & pending[issue_wa] & !(mc_done & mc_wa==issue_wa).
- stall = OR of all port stalls and structural stall, gated by issue_valid & !flush.
- An issue is accepted when issue_valid & !stall & !flush.
- Scoreboard update, registered:
  - On accepted issue with issue_multi & issue_wa!=0: set pending[issue_wa].
  - On mc_done & mc_wa!=0: clear pending[mc_wa].
  - Same register set and cleared in one cycle: set wins.
  - pending[0] is always 0.
- mc_count:
  - +1 on accepted issue_multi (including issue_wa==0).
  - -1 on mc_done.
  - Both in the same cycle: unchanged.
  - mc_done while mc_count==0: ignored, no underflow. Never exceeds MC_DEPTH.
- flush suppresses stall and scoreboard set that cycle. Already-outstanding ops stay pending until mc_done.
- stall_cycles +1 each cycle stall=1; holds at 32'hFFFF_FFFF.
- Reset (reset==0 at clk edge):
  - pending=0, mc_count=0, stall_cycles=0.
  - While reset is low, stall=0 and rs=0.
  - An in-flight mc_done during reset is dropped.

Test Plan:
- ra0=5, src_valid=3'b011, src_wa[0]=src_wa[1]=5, src_data[0]=0xA, src_data[1]=0xB, ready=all -> rs0=0xA, stall=0.
- ra1=7, src_valid[0]=1, src_wa[0]=7, src_ready[0]=0, issue_valid=1 -> stall=1; stall_cycles increments each held cycle; ready=1 next cycle -> rs1=src_data[0], stall=0.
- Issue multi to x9; next cycle ra0=9 -> stall until mc_done with mc_wa=9, mc_data=0x1234 -> same cycle rs0=0x1234, stall=0, pending[9] cleared next edge.
- MC_DEPTH=2: two accepted multi issues, third issue_multi -> stall, mc_count=2; mc_done same cycle as third issue -> accepted, mc_count stays 2.
- Accepted multi issue to x3 with mc_done mc_wa=3 in the same cycle -> pending[3]=1 afterwards.
- ra=0 with src_wa=0 valid -> rs=0. flush=1 with hazard -> stall=0, no pending set. reset low mid-run -> pending=0, mc_count=0, stall_cycles=0 next edge.
